// File: rtl/dds_dual_nco.sv
// Dual NCO: 16-bit offset-binary sine carrier plus a selectable modulating wave.
// Optional feature macro: DDS_PHASE_SYNC_EN adds the phase_sync accumulator-clear input.
module dds_dual_nco #(
  parameter int PHASE_W = 32,
  parameter int LUT_AW  = 10,
  parameter int OUT_W   = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               enable,
  input  logic [PHASE_W-1:0] ftw_car,
  input  logic [PHASE_W-1:0] ftw_mod,
  input  logic [1:0]         wave_sel,
  input  logic               cfg_load,
`ifdef DDS_PHASE_SYNC_EN
  input  logic               phase_sync,
`endif
  output logic               cfg_ack,
  output logic [OUT_W-1:0]   carrier,
  output logic [OUT_W-1:0]   modulated,
  output logic               sample_valid
);

  localparam int P_W = OUT_W + 1;
  localparam logic [OUT_W-1:0] MID = {1'b1, {(OUT_W-1){1'b0}}};

  // Elaboration-time sine entry: Taylor series on an angle folded into [-pi, pi].
  function automatic logic [OUT_W-1:0] sine_entry(input int k);
    real pi, x, term, sum, scaled;
    int  r;
    pi  = 3.14159265358979323846;
    x   = 2.0 * pi * real'(k) / real'(2 ** LUT_AW);
    if (x > pi) x = x - 2.0 * pi;
    term = x;
    sum  = x;
    for (int n = 1; n < 24; n++) begin
      term = -term * x * x / real'((2 * n) * (2 * n + 1));
      sum  = sum + term;
    end
    scaled = real'(2 ** (OUT_W - 1) - 1) * sum;
    r = (scaled >= 0.0) ? $rtoi(scaled + 0.5) : -$rtoi(0.5 - scaled);
    return OUT_W'(2 ** (OUT_W - 1) + r);
  endfunction

  logic [OUT_W-1:0] sine_rom [2**LUT_AW];

  for (genvar k = 0; k < 2**LUT_AW; k++) begin : g_rom
    localparam logic [OUT_W-1:0] ENTRY = sine_entry(k);
    assign sine_rom[k] = ENTRY;
  end

  logic [PHASE_W-1:0] acc_car_q, acc_car_d, acc_mod_q, acc_mod_d;
  logic [PHASE_W-1:0] sh_car_q, sh_car_d, sh_mod_q, sh_mod_d;
  logic [PHASE_W-1:0] act_car_q, act_car_d, act_mod_q, act_mod_d;
  logic [1:0]         sh_ws_q, sh_ws_d, act_ws_q, act_ws_d;
  logic               ack_q, ack_d;
  logic [2:0]         valid_q, valid_d;
  logic [LUT_AW-1:0]  s1_car_addr_q, s1_car_addr_d;
  logic [P_W-1:0]     s1_mod_p_q, s1_mod_p_d;
  logic [1:0]         s1_ws_q, s1_ws_d;
  logic [OUT_W-1:0]   s2_car_q, s2_car_d, s2_mod_q, s2_mod_d;
  logic [OUT_W-1:0]   carrier_q, carrier_d, modulated_q, modulated_d;

  always_comb begin
    sh_car_d      = sh_car_q;
    sh_mod_d      = sh_mod_q;
    sh_ws_d       = sh_ws_q;
    act_car_d     = act_car_q;
    act_mod_d     = act_mod_q;
    act_ws_d      = act_ws_q;
    acc_car_d     = acc_car_q;
    acc_mod_d     = acc_mod_q;
    s1_car_addr_d = s1_car_addr_q;
    s1_mod_p_d    = s1_mod_p_q;
    s1_ws_d       = s1_ws_q;
    s2_car_d      = s2_car_q;
    s2_mod_d      = s2_mod_q;
    carrier_d     = carrier_q;
    modulated_d   = modulated_q;
    ack_d         = cfg_load;
    valid_d       = {valid_q[1:0], enable};

    if (cfg_load) begin
      sh_car_d = ftw_car;
      sh_mod_d = ftw_mod;
      sh_ws_d  = wave_sel;
    end
    // ack_q marks a capture from the previous cycle; activate all three fields at once
    if (ack_q) begin
      act_car_d = sh_car_q;
      act_mod_d = sh_mod_q;
      act_ws_d  = sh_ws_q;
    end

`ifdef DDS_PHASE_SYNC_EN
    if (phase_sync) begin
      acc_car_d = '0;
      acc_mod_d = '0;
    end else if (enable) begin
      acc_car_d = acc_car_q + act_car_q;
      acc_mod_d = acc_mod_q + act_mod_q;
    end
`else
    if (enable) begin
      acc_car_d = acc_car_q + act_car_q;
      acc_mod_d = acc_mod_q + act_mod_q;
    end
`endif

    // wave select travels with its phase so a config change never splits a sample
    if (enable) begin
      s1_car_addr_d = acc_car_q[PHASE_W-1 -: LUT_AW];
      s1_mod_p_d    = acc_mod_q[PHASE_W-1 -: P_W];
      s1_ws_d       = act_ws_q;
      s2_car_d      = sine_rom[s1_car_addr_q];
      case (s1_ws_q)
        2'd0:    s2_mod_d = sine_rom[s1_mod_p_q[P_W-1 -: LUT_AW]];
        2'd1:    s2_mod_d = {OUT_W{~s1_mod_p_q[P_W-1]}};
        2'd2:    s2_mod_d = s1_mod_p_q[P_W-1] ? ~s1_mod_p_q[OUT_W-1:0] : s1_mod_p_q[OUT_W-1:0];
        default: s2_mod_d = s1_mod_p_q[P_W-1:1];
      endcase
      carrier_d   = s2_car_q;
      modulated_d = s2_mod_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_car_q     <= '0;
      acc_mod_q     <= '0;
      sh_car_q      <= '0;
      sh_mod_q      <= '0;
      sh_ws_q       <= '0;
      act_car_q     <= '0;
      act_mod_q     <= '0;
      act_ws_q      <= '0;
      ack_q         <= 1'b0;
      valid_q       <= '0;
      s1_car_addr_q <= '0;
      s1_mod_p_q    <= '0;
      s1_ws_q       <= '0;
      s2_car_q      <= MID;
      s2_mod_q      <= MID;
      carrier_q     <= MID;
      modulated_q   <= MID;
    end else begin
      acc_car_q     <= acc_car_d;
      acc_mod_q     <= acc_mod_d;
      sh_car_q      <= sh_car_d;
      sh_mod_q      <= sh_mod_d;
      sh_ws_q       <= sh_ws_d;
      act_car_q     <= act_car_d;
      act_mod_q     <= act_mod_d;
      act_ws_q      <= act_ws_d;
      ack_q         <= ack_d;
      valid_q       <= valid_d;
      s1_car_addr_q <= s1_car_addr_d;
      s1_mod_p_q    <= s1_mod_p_d;
      s1_ws_q       <= s1_ws_d;
      s2_car_q      <= s2_car_d;
      s2_mod_q      <= s2_mod_d;
      carrier_q     <= carrier_d;
      modulated_q   <= modulated_d;
    end
  end

  assign cfg_ack      = ack_q;
  assign carrier      = carrier_q;
  assign modulated    = modulated_q;
  assign sample_valid = valid_q[2];

endmodule

// File: tb/tb_dds_dual_nco.sv
// Self-checking bench for dds_dual_nco: a phase-level reference model compared every
// cycle, plus directed literal checks on handshake, latency, waveform shape and wrap.
module tb_dds_dual_nco;

  logic        clk;
  logic        rst_n;
  logic        enable;
  logic [31:0] ftw_car;
  logic [31:0] ftw_mod;
  logic [1:0]  wave_sel;
  logic        cfg_load;
`ifdef DDS_PHASE_SYNC_EN
  logic        phase_sync;
`endif
  logic        cfg_ack;
  logic [15:0] carrier;
  logic [15:0] modulated;
  logic        sample_valid;

  int tests_run    = 0;
  int tests_failed = 0;
  logic check_en   = 1'b0;

  dds_dual_nco dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .enable      (enable),
    .ftw_car     (ftw_car),
    .ftw_mod     (ftw_mod),
    .wave_sel    (wave_sel),
    .cfg_load    (cfg_load),
`ifdef DDS_PHASE_SYNC_EN
    .phase_sync  (phase_sync),
`endif
    .cfg_ack     (cfg_ack),
    .carrier     (carrier),
    .modulated   (modulated),
    .sample_valid(sample_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference waveforms computed straight from the phase value.
  function automatic logic [15:0] sine_ref(input int k);
    real v;
    int  r;
    v = 32767.0 * $sin(2.0 * 3.14159265358979323846 * real'(k) / 1024.0);
    r = $rtoi($floor(v + 0.5));
    return 16'(32768 + r);
  endfunction

  function automatic logic [15:0] wave_ref(input logic [31:0] ph, input logic [1:0] ws);
    case (ws)
      2'd0:    return sine_ref(int'(ph[31:22]));
      2'd1:    return ph[31] ? 16'h0000 : 16'hFFFF;
      2'd2:    return ph[31] ? ~ph[30:15] : ph[30:15];
      default: return ph[31:16];
    endcase
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input logic en, input logic [31:0] fc, input logic [31:0] fm,
                               input logic [1:0] ws);
    enable   = en;
    ftw_car  = fc;
    ftw_mod  = fm;
    wave_sel = ws;
  endtask

  task automatic stepCycles(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  // Issues one cfg_load pulse and checks the ack lands in the following cycle only.
  task automatic loadConfig(input logic [31:0] fc, input logic [31:0] fm, input logic [1:0] ws);
    ftw_car  = fc;
    ftw_mod  = fm;
    wave_sel = ws;
    cfg_load = 1'b1;
    stepCycles(1);
    cfg_load = 1'b0;
    checkOutput("cfg_ack_n_plus_1", cfg_ack, 1);
    stepCycles(1);
    checkOutput("cfg_ack_single_pulse", cfg_ack, 0);
  endtask

  // Reference model: config shadow/active, phase accumulators, and a
  // three-deep history of phases taken on each enabled clock.
  logic [31:0] m_sh_car, m_sh_mod, m_act_car, m_act_mod, m_acc_car, m_acc_mod;
  logic [1:0]  m_sh_ws, m_act_ws;
  logic        m_pend;
  logic [2:0]  m_vp;
  logic [31:0] h_car [3];
  logic [31:0] h_mod [3];
  logic [1:0]  h_ws  [3];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_sh_car  <= '0;
      m_sh_mod  <= '0;
      m_sh_ws   <= '0;
      m_act_car <= '0;
      m_act_mod <= '0;
      m_act_ws  <= '0;
      m_acc_car <= '0;
      m_acc_mod <= '0;
      m_pend    <= 1'b0;
      m_vp      <= '0;
      for (int i = 0; i < 3; i++) begin
        h_car[i] <= '0;
        h_mod[i] <= '0;
        h_ws[i]  <= '0;
      end
    end else begin
      m_pend <= cfg_load;
      m_vp   <= {m_vp[1:0], enable};
      if (cfg_load) begin
        m_sh_car <= ftw_car;
        m_sh_mod <= ftw_mod;
        m_sh_ws  <= wave_sel;
      end
      if (m_pend) begin
        m_act_car <= m_sh_car;
        m_act_mod <= m_sh_mod;
        m_act_ws  <= m_sh_ws;
      end
`ifdef DDS_PHASE_SYNC_EN
      if (phase_sync) begin
        m_acc_car <= '0;
        m_acc_mod <= '0;
      end else if (enable) begin
        m_acc_car <= m_acc_car + m_act_car;
        m_acc_mod <= m_acc_mod + m_act_mod;
      end
`else
      if (enable) begin
        m_acc_car <= m_acc_car + m_act_car;
        m_acc_mod <= m_acc_mod + m_act_mod;
      end
`endif
      if (enable) begin
        h_car[0] <= m_acc_car;
        h_mod[0] <= m_acc_mod;
        h_ws[0]  <= m_act_ws;
        for (int i = 1; i < 3; i++) begin
          h_car[i] <= h_car[i-1];
          h_mod[i] <= h_mod[i-1];
          h_ws[i]  <= h_ws[i-1];
        end
      end
    end
  end

  always @(negedge clk) begin
    if (check_en) begin
      checkOutput("carrier", carrier, sine_ref(int'(h_car[2][31:22])));
      checkOutput("modulated", modulated, wave_ref(h_mod[2], h_ws[2]));
      checkOutput("sample_valid", sample_valid, m_vp[2]);
      checkOutput("cfg_ack", cfg_ack, m_pend);
    end
  end

  initial begin
    int cnt_peak, cnt_trough, cnt_toggle, cnt_bad;
    logic [15:0] prev;

    rst_n    = 1'b0;
    cfg_load = 1'b0;
`ifdef DDS_PHASE_SYNC_EN
    phase_sync = 1'b0;
`endif
    applyStimulus(1'b0, 32'h0, 32'h0, 2'd0);
    stepCycles(3);
    rst_n = 1'b1;
    stepCycles(1);
    check_en = 1'b1;

    checkOutput("reset_carrier", carrier, 16'h8000);
    checkOutput("reset_modulated", modulated, 16'h8000);
    checkOutput("reset_sample_valid", sample_valid, 0);
    checkOutput("reset_cfg_ack", cfg_ack, 0);

    // Carrier at 1/256 of the clock, slow sine on the modulating channel.
    loadConfig(32'h0100_0000, 32'h0020_0000, 2'd0);
    stepCycles(1);
    enable = 1'b1;
    stepCycles(2);
    checkOutput("valid_rise_early", sample_valid, 0);
    stepCycles(1);
    checkOutput("valid_rise_3clk", sample_valid, 1);

    stepCycles(8);
    cnt_peak   = 0;
    cnt_trough = 0;
    for (int i = 0; i < 512; i++) begin
      stepCycles(1);
      if (carrier == 16'hFFFF) cnt_peak++;
      if (carrier == 16'h0001) cnt_trough++;
    end
    checkOutput("carrier_peak_count", cnt_peak, 2);
    checkOutput("carrier_trough_count", cnt_trough, 2);

    // Square modulating wave: half period 16 clk.
    loadConfig(32'h0100_0000, 32'h0800_0000, 2'd1);
    stepCycles(8);
    cnt_toggle = 0;
    cnt_bad    = 0;
    prev       = modulated;
    for (int i = 0; i < 128; i++) begin
      stepCycles(1);
      if (modulated != prev) cnt_toggle++;
      if (modulated != 16'hFFFF && modulated != 16'h0000) cnt_bad++;
      prev = modulated;
    end
    checkOutput("square_toggles", cnt_toggle, 8);
    checkOutput("square_levels", cnt_bad, 0);

    loadConfig(32'h0100_0000, 32'h0123_4567, 2'd2);
    stepCycles(64);
    loadConfig(32'h8000_0000, 32'h8000_0000, 2'd3);
    stepCycles(16);
    loadConfig(32'h0345_6789, 32'h0000_0000, 2'd3);
    stepCycles(16);

    // Hold: outputs freeze while the valid pipeline drains.
    enable = 1'b0;
    stepCycles(2);
    checkOutput("valid_fall_early", sample_valid, 1);
    stepCycles(1);
    checkOutput("valid_fall_3clk", sample_valid, 0);
    stepCycles(6);
    loadConfig(32'h0100_0000, 32'h0800_0000, 2'd1);
    stepCycles(4);
    enable = 1'b1;
    stepCycles(40);

    // Wrap: all-ones tuning word steps the phase backwards from zero.
    rst_n  = 1'b0;
    enable = 1'b0;
    stepCycles(2);
    rst_n = 1'b1;
    loadConfig(32'hFFFF_FFFF, 32'h0000_0000, 2'd0);
    stepCycles(1);
    enable = 1'b1;
    stepCycles(6);
    checkOutput("wrap_carrier", carrier, 16'h7F37);
    stepCycles(20);

    // Reset with a capture in flight: no ack, active words stay zero.
    enable   = 1'b0;
    ftw_car  = 32'h0100_0000;
    cfg_load = 1'b1;
    stepCycles(1);
    cfg_load = 1'b0;
    rst_n    = 1'b0;
    #1;
    checkOutput("reset_drops_ack", cfg_ack, 0);
    stepCycles(1);
    rst_n  = 1'b1;
    enable = 1'b1;
    stepCycles(10);
    checkOutput("lost_load_carrier", carrier, 16'h8000);

`ifdef DDS_PHASE_SYNC_EN
    loadConfig(32'h0100_0000, 32'h0020_0000, 2'd0);
    stepCycles(20);
    phase_sync = 1'b1;
    stepCycles(1);
    phase_sync = 1'b0;
    stepCycles(3);
    checkOutput("sync_carrier", carrier, 16'h8000);
    checkOutput("sync_modulated", modulated, 16'h8000);
    stepCycles(10);
`endif

    check_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
